// File: rtl/mac_stream_source.sv
// rtl/mac_stream_source.sv - TCDM load streamer feeding the MAC engine; `define MAC_STREAM_SOURCE_PERF_EN adds stall/backpressure counters
module mac_stream_source #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TRANS_CNT  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  req_start_i,
    output logic                  ready_start_o,
    output logic                  done_o,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [TRANS_CNT-1:0]  trans_size_i,
    output logic                  tcdm_req_o,
    input  logic                  tcdm_gnt_i,
    output logic [ADDR_WIDTH-1:0] tcdm_add_o,
    input  logic                  tcdm_r_valid_i,
    input  logic [DATA_WIDTH-1:0] tcdm_r_data_i,
`ifdef MAC_STREAM_SOURCE_PERF_EN
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           bp_cnt_o,
`endif
    output logic                  stream_valid_o,
    output logic [DATA_WIDTH-1:0] stream_data_o,
    input  logic                  stream_ready_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W:0]     DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   FULL_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   ONE_C   = CNT_W'(1);
    localparam logic [PTR_W-1:0]   ONE_P   = PTR_W'(1);
    localparam logic [TRANS_CNT-1:0] ONE_T = TRANS_CNT'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    // Transfer control state
    state_e                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [TRANS_CNT-1:0]  size_q;
    logic [TRANS_CNT-1:0]  issued_q;
    logic [TRANS_CNT-1:0]  received_q;
    logic [CNT_W-1:0]      outst_q;
    logic [CNT_W-1:0]      outst_d;
    logic                  done_q;

    // Response FIFO state
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      fifo_cnt_q;
    logic [CNT_W-1:0]      fifo_cnt_d;

    logic                  fifo_empty_w;
    logic                  fifo_full_w;
    logic                  credit_ok_w;
    logic                  gnt_fire_w;
    logic                  push_w;
    logic                  pop_w;
    logic                  start_w;
    logic [CNT_W:0]        inflight_w;

    assign fifo_empty_w = (fifo_cnt_q == '0);
    assign fifo_full_w  = (fifo_cnt_q == FULL_C);

    // Words already granted plus words waiting in the FIFO may never exceed the
    // FIFO depth, so every response has a guaranteed slot.
    assign inflight_w  = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
    assign credit_ok_w = (inflight_w < DEPTH_C);

    // Request and address depend only on registered state; credit can only grow
    // while a request waits, so the request never drops before its grant.
    assign tcdm_req_o = (state_q == S_RUN) && (issued_q < size_q) && credit_ok_w;
    assign tcdm_add_o = (state_q == S_RUN) ? (base_q + (ADDR_WIDTH'(issued_q) << 2)) : '0;

    assign gnt_fire_w = tcdm_req_o && tcdm_gnt_i;

    // Responses seen while idle belong to a transfer that was cleared.
    assign push_w  = tcdm_r_valid_i && (state_q != S_IDLE);
    assign pop_w   = !fifo_empty_w && stream_ready_i;
    assign start_w = (state_q == S_IDLE) && req_start_i;

    assign ready_start_o  = (state_q == S_IDLE);
    assign done_o         = done_q;
    assign stream_valid_o = !fifo_empty_w;
    assign stream_data_o  = fifo_empty_w ? '0 : mem_q[rd_ptr_q];

    // Next occupancy of the response FIFO
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (push_w && !pop_w) begin
            fifo_cnt_d = fifo_cnt_q + ONE_C;
        end else if (!push_w && pop_w) begin
            fifo_cnt_d = fifo_cnt_q - ONE_C;
        end
    end

    // Next count of granted-but-not-yet-returned reads
    always_comb begin
        outst_d = outst_q;
        if (gnt_fire_w && !push_w) begin
            outst_d = outst_q + ONE_C;
        end else if (!gnt_fire_w && push_w) begin
            outst_d = outst_q - ONE_C;
        end
    end

    // Transfer FSM: start latching, issue counting, drain and completion pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            size_q     <= '0;
            issued_q   <= '0;
            received_q <= '0;
            outst_q    <= '0;
            done_q     <= 1'b0;
        end else if (clear_i) begin
            state_q    <= S_IDLE;
            issued_q   <= '0;
            received_q <= '0;
            outst_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            outst_q <= outst_d;
            if (push_w) begin
                received_q <= received_q + ONE_T;
            end
            case (state_q)
                S_IDLE: begin
                    if (req_start_i) begin
                        if (trans_size_i != '0) begin
                            base_q     <= base_addr_i;
                            size_q     <= trans_size_i;
                            issued_q   <= '0;
                            received_q <= '0;
                            outst_q    <= '0;
                            state_q    <= S_RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (gnt_fire_w) begin
                        issued_q <= issued_q + ONE_T;
                        if ((issued_q + ONE_T) == size_q) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((received_q == size_q) && fifo_empty_w) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else if (clear_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push_w) begin
                wr_ptr_q <= wr_ptr_q + ONE_P;
            end
            if (pop_w) begin
                rd_ptr_q <= rd_ptr_q + ONE_P;
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // FIFO storage; contents are only visible while the FIFO is non-empty
    always_ff @(posedge clk_i) begin
        if (push_w && !clear_i) begin
            mem_q[wr_ptr_q] <= tcdm_r_data_i;
        end
    end

    // A push into a full FIFO without a same-cycle pop means the credit logic is broken
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_w && !clear_i && fifo_full_w && !pop_w));

`ifdef MAC_STREAM_SOURCE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bp_cnt_q;

    // Saturating stall and backpressure counters, restarted on every accepted start
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            bp_cnt_q    <= '0;
        end else if (clear_i || start_w) begin
            stall_cnt_q <= '0;
            bp_cnt_q    <= '0;
        end else begin
            if (tcdm_req_o && !tcdm_gnt_i && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (stream_valid_o && !stream_ready_i && (bp_cnt_q != '1)) begin
                bp_cnt_q <= bp_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign bp_cnt_o    = bp_cnt_q;
`else
    logic unused_start_w;
    assign unused_start_w = start_w;
`endif

endmodule

// File: tb/tb_mac_stream_source.sv
// tb/tb_mac_stream_source.sv - self-checking bench for mac_stream_source
module tb_mac_stream_source;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic        req_start_i;
    logic        ready_start_o;
    logic        done_o;
    logic [31:0] base_addr_i;
    logic [15:0] trans_size_i;
    logic        tcdm_req_o;
    logic        tcdm_gnt_i;
    logic [31:0] tcdm_add_o;
    logic        tcdm_r_valid_i;
    logic [31:0] tcdm_r_data_i;
    logic        stream_valid_o;
    logic [31:0] stream_data_o;
    logic        stream_ready_i;
`ifdef MAC_STREAM_SOURCE_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] bp_cnt_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    mac_stream_source dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clear_i        (clear_i),
        .req_start_i    (req_start_i),
        .ready_start_o  (ready_start_o),
        .done_o         (done_o),
        .base_addr_i    (base_addr_i),
        .trans_size_i   (trans_size_i),
        .tcdm_req_o     (tcdm_req_o),
        .tcdm_gnt_i     (tcdm_gnt_i),
        .tcdm_add_o     (tcdm_add_o),
        .tcdm_r_valid_i (tcdm_r_valid_i),
        .tcdm_r_data_i  (tcdm_r_data_i),
`ifdef MAC_STREAM_SOURCE_PERF_EN
        .stall_cnt_o    (stall_cnt_o),
        .bp_cnt_o       (bp_cnt_o),
`endif
        .stream_valid_o (stream_valid_o),
        .stream_data_o  (stream_data_o),
        .stream_ready_i (stream_ready_i)
    );

    // gmode: 0 always grant, 1 grant on even cycles, 2 random
    // rmode: 0 always ready, 1 random, 2 ready held low for cycles 1..20
    typedef struct {
        logic [31:0] base;
        int          size;
        int          gmode;
        int          rmode;
        bit          pulse;
        int          exp_lat;
        int          exp_hold_grants;
        int          exp_stall;
    } vec_t;

    // Memory image seen through TCDM: a bijection of the address, so any lost,
    // duplicated or reordered word shows up as a data difference.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_96E1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input vec_t v);
        logic [31:0] exp_addr[$];
        logic [31:0] got_addr[$];
        logic [31:0] got_data[$];
        int          done_cnt    = 0;
        int          done_k      = -1;
        int          first_valid = -1;
        int          first_g     = -1;
        int          last_g      = -1;
        int          last_pop    = -1;
        int          hold_grants = 0;
        int          stall_seen  = 0;
        int          bp_seen     = 0;
        logic        req_low_at_hold = 1'b0;
        logic        rsp_pend    = 1'b0;
        logic        prev_stall  = 1'b0;
        logic [31:0] rsp_addr    = '0;
        logic [31:0] prev_addr   = '0;

        for (int i = 0; i < v.size; i++) begin
            exp_addr.push_back(v.base + 32'(4 * i));
        end

        @(negedge clk_i);
        base_addr_i    = v.base;
        trans_size_i   = 16'(v.size);
        req_start_i    = 1'b1;
        tcdm_gnt_i     = 1'b0;
        stream_ready_i = 1'b0;
        tcdm_r_valid_i = 1'b0;

        for (int k = 1; k <= 400; k++) begin
            @(negedge clk_i);
            req_start_i  = 1'b0;
            base_addr_i  = $urandom;
            trans_size_i = 16'($urandom);
            if (k == 1) check("busy_after_start", 32'(ready_start_o), 32'd0);
            if (done_o) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (prev_stall) begin
                check("req_held", 32'(tcdm_req_o), 32'd1);
                check("addr_held", tcdm_add_o, prev_addr);
            end

            tcdm_r_valid_i = rsp_pend;
            tcdm_r_data_i  = rsp_pend ? mem_word(rsp_addr) : $urandom;
            rsp_pend       = 1'b0;

            case (v.gmode)
                0:       tcdm_gnt_i = 1'b1;
                1:       tcdm_gnt_i = (k % 2 == 0);
                default: tcdm_gnt_i = 1'($urandom_range(0, 1));
            endcase
            case (v.rmode)
                0:       stream_ready_i = 1'b1;
                1:       stream_ready_i = 1'($urandom_range(0, 1));
                default: stream_ready_i = (k > 20);
            endcase

            if (v.rmode == 2 && k == 20) req_low_at_hold = !tcdm_req_o;
            if (tcdm_req_o && tcdm_gnt_i) begin
                got_addr.push_back(tcdm_add_o);
                rsp_pend = 1'b1;
                rsp_addr = tcdm_add_o;
                if (first_g < 0) first_g = k;
                last_g = k;
                if (v.rmode == 2 && k <= 20) hold_grants++;
            end
            prev_stall = tcdm_req_o && !tcdm_gnt_i;
            prev_addr  = tcdm_add_o;
            if (prev_stall) stall_seen++;

            if (stream_valid_o && first_valid < 0) first_valid = k;
            if (stream_valid_o && stream_ready_i) begin
                got_data.push_back(stream_data_o);
                last_pop = k;
            end
            if (stream_valid_o && !stream_ready_i) bp_seen++;

            if (v.pulse && k == 4) begin
                req_start_i  = 1'b1;
                base_addr_i  = 32'hDEAD_0000;
                trans_size_i = 16'd3;
            end
            if (done_k >= 0 && k >= done_k + 3) break;
        end

        tcdm_gnt_i     = 1'b0;
        stream_ready_i = 1'b0;
        tcdm_r_valid_i = 1'b0;
        @(negedge clk_i);

        check("done_pulses", 32'(done_cnt), 32'd1);
        check("ready_after_done", 32'(ready_start_o), 32'd1);
        check("grant_count", 32'(got_addr.size()), 32'(v.size));
        check("beat_count", 32'(got_data.size()), 32'(v.size));
        for (int i = 0; i < v.size; i++) begin
            if (i < got_addr.size()) check("addr_seq", got_addr[i], exp_addr[i]);
            if (i < got_data.size()) check("beat_data", got_data[i], mem_word(exp_addr[i]));
        end
        check("done_after_last_beat", 32'(done_k > last_pop), 32'd1);
        if (v.exp_lat >= 0) begin
            check("first_valid_latency", 32'(first_valid), 32'(v.exp_lat));
            check("grants_back_to_back", 32'(last_g - first_g), 32'(v.size - 1));
        end
        if (v.exp_hold_grants >= 0) begin
            check("grants_while_blocked", 32'(hold_grants), 32'(v.exp_hold_grants));
            check("req_low_while_blocked", 32'(req_low_at_hold), 32'd1);
        end
        if (v.exp_stall >= 0) check("stall_cycles", 32'(stall_seen), 32'(v.exp_stall));
`ifdef MAC_STREAM_SOURCE_PERF_EN
        check("stall_cnt", stall_cnt_o, 32'(stall_seen));
        check("bp_cnt", bp_cnt_o, 32'(bp_seen));
`endif
    endtask

    vec_t vecs[10];
    vec_t tail;

    initial begin
        vecs[0] = '{base: 32'h0000_1000, size: 4, gmode: 0, rmode: 0, pulse: 1'b0,
                    exp_lat: 3, exp_hold_grants: -1, exp_stall: 0};
        vecs[1] = '{base: 32'h0000_4000, size: 8, gmode: 0, rmode: 2, pulse: 1'b0,
                    exp_lat: -1, exp_hold_grants: 4, exp_stall: -1};
        vecs[2] = '{base: 32'hFFFF_FFF8, size: 4, gmode: 1, rmode: 0, pulse: 1'b0,
                    exp_lat: -1, exp_hold_grants: -1, exp_stall: 4};
        vecs[3] = '{base: 32'h0000_5000, size: 6, gmode: 0, rmode: 0, pulse: 1'b1,
                    exp_lat: 3, exp_hold_grants: -1, exp_stall: 0};
        for (int i = 4; i < 10; i++) begin
            vecs[i] = '{base: $urandom, size: int'($urandom_range(1, 12)), gmode: 2, rmode: 1,
                        pulse: 1'(i % 2), exp_lat: -1, exp_hold_grants: -1, exp_stall: -1};
        end

        rst_i          = 1'b1;
        clear_i        = 1'b0;
        req_start_i    = 1'b0;
        base_addr_i    = '0;
        trans_size_i   = '0;
        tcdm_gnt_i     = 1'b0;
        tcdm_r_valid_i = 1'b0;
        tcdm_r_data_i  = '0;
        stream_ready_i = 1'b0;

        repeat (2) @(negedge clk_i);
        check("rst_ready_start", 32'(ready_start_o), 32'd1);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_req", 32'(tcdm_req_o), 32'd0);
        check("rst_valid", 32'(stream_valid_o), 32'd0);
        check("rst_add", tcdm_add_o, 32'd0);
        check("rst_data", stream_data_o, 32'd0);
`ifdef MAC_STREAM_SOURCE_PERF_EN
        check("rst_stall_cnt", stall_cnt_o, 32'd0);
        check("rst_bp_cnt", bp_cnt_o, 32'd0);
`endif
        rst_i = 1'b0;

        // Zero-length start: immediate done, no TCDM traffic
        @(negedge clk_i);
        base_addr_i  = 32'h0000_8000;
        trans_size_i = 16'd0;
        req_start_i  = 1'b1;
        tcdm_gnt_i   = 1'b1;
        @(negedge clk_i);
        req_start_i = 1'b0;
        check("zero_done", 32'(done_o), 32'd1);
        check("zero_ready", 32'(ready_start_o), 32'd1);
        check("zero_req", 32'(tcdm_req_o), 32'd0);
        @(negedge clk_i);
        check("zero_done_once", 32'(done_o), 32'd0);
        check("zero_req_after", 32'(tcdm_req_o), 32'd0);
        tcdm_gnt_i = 1'b0;

        for (int i = 0; i < 10; i++) run_xfer(vecs[i]);

        // Clear after two grants of a six-word transfer
        @(negedge clk_i);
        base_addr_i    = 32'h0000_2000;
        trans_size_i   = 16'd6;
        req_start_i    = 1'b1;
        tcdm_gnt_i     = 1'b1;
        stream_ready_i = 1'b0;
        @(negedge clk_i);
        req_start_i = 1'b0;
        check("clr_req1", 32'(tcdm_req_o), 32'd1);
        check("clr_add1", tcdm_add_o, 32'h0000_2000);
        @(negedge clk_i);
        tcdm_r_valid_i = 1'b1;
        tcdm_r_data_i  = mem_word(32'h0000_2000);
        check("clr_add2", tcdm_add_o, 32'h0000_2004);
        @(negedge clk_i);
        check("clr_valid_before", 32'(stream_valid_o), 32'd1);
        tcdm_r_valid_i = 1'b1;
        tcdm_r_data_i  = mem_word(32'h0000_2004);
        tcdm_gnt_i     = 1'b0;
        clear_i        = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        check("clr_idle", 32'(ready_start_o), 32'd1);
        check("clr_valid", 32'(stream_valid_o), 32'd0);
        check("clr_req", 32'(tcdm_req_o), 32'd0);
        check("clr_done", 32'(done_o), 32'd0);
        tcdm_r_valid_i = 1'b1;
        tcdm_r_data_i  = 32'hBAD0_0001;
        @(negedge clk_i);
        tcdm_r_valid_i = 1'b0;
        check("clr_late_dropped", 32'(stream_valid_o), 32'd0);
        check("clr_done_late", 32'(done_o), 32'd0);
        @(negedge clk_i);
        check("clr_done_later", 32'(done_o), 32'd0);

        tail = '{base: 32'h0000_3000, size: 2, gmode: 0, rmode: 0, pulse: 1'b0,
                 exp_lat: 3, exp_hold_grants: -1, exp_stall: 0};
        run_xfer(tail);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
